// File: rtl/debug_dump_controller.sv
// -----------------------------------------------------------------------------
// debug_dump_controller
//
// Sits downstream of the processor's halt/debug interface. When the processor
// halts, the block reads r0..r(REG_COUNT-1) and ip through the debug port and
// streams them as one byte frame over a ready/valid byte link to the UART
// transmitter:
//
//   HEADER_BYTE, then for each word (registers first, ip last) three bytes
//   sent least significant byte first. Each word is zero-extended to 24 bits.
//
// After the frame the block waits for a host command byte:
//   'C' (8'h43) : pulse wait_continue_execution for one cycle, then wait for
//                 the halt flag to clear before arming again.
//   'D' (8'h44) : send the whole frame again.
//   other bytes : dropped.
// If the halt flag drops while waiting for a command, the block returns to
// IDLE without pulsing resume.
//
// WORD_SIZE must lie in 17..24 so that every word fits in exactly 3 bytes.
// -----------------------------------------------------------------------------
module debug_dump_controller #(
    parameter int unsigned WORD_SIZE   = 18,
    parameter int unsigned REG_COUNT   = 8,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,

    // processor halt / resume handshake
    input  logic                 wait_for_continue,
    output logic                 wait_continue_execution,

    // debug register read port
    output logic                 debug_get_param,
    output logic [3:0]           debug_reg_addr,
    input  logic [WORD_SIZE-1:0] debug_data_out,

    // byte stream towards the UART transmitter
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,

    // host command bytes from the UART receiver
    input  logic                 cmd_valid,
    input  logic [7:0]           cmd_data,
    output logic                 cmd_ready,

    output logic                 busy
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [7:0] CMD_RESUME = 8'h43;   // 'C'
    localparam logic [7:0] CMD_REDUMP = 8'h44;   // 'D'

    // Debug address of ip; it is also the index of the last word in a frame.
    localparam logic [3:0] LAST_INDEX = 4'(REG_COUNT);

    // Bytes per word minus one: the byte counter value of the final byte.
    localparam logic [1:0] LAST_BYTE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,        // waiting for the processor to halt
        S_HEADER,      // presenting the frame header byte
        S_RD_ADDR,     // driving the debug address for the current word
        S_RD_CAP,      // debug data valid now; capture it
        S_SEND,        // presenting the three bytes of the captured word
        S_WAIT_CMD,    // frame done, waiting for a host command
        S_RESUME,      // one-cycle resume pulse to the processor
        S_WAIT_CLEAR   // waiting for the halt flag to fall after resume
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,    state_d;
    logic [3:0]  index_q,    index_d;      // word being dumped (0..REG_COUNT)
    logic [1:0]  byte_cnt_q, byte_cnt_d;   // byte of the word on the link
    logic [23:0] word_q,     word_d;       // captured word, shifted per byte

    // Host command byte, registered once it has been accepted in WAIT_CMD.
    // Only bytes that arrive while the frame is finished are kept; anything
    // received during a dump, resume or idle is discarded here.
    logic        cmd_vld_q;
    logic [7:0]  cmd_byte_q;

    // The command input is never back-pressured.
    assign cmd_ready = 1'b1;

    // Every state except IDLE counts as busy.
    assign busy = (state_q != S_IDLE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values that were present before this clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

    // Capture a host command byte only while a command is being awaited.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_vld_q  <= 1'b0;
            cmd_byte_q <= '0;
        end else begin
            cmd_vld_q  <= cmd_valid && (state_q == S_WAIT_CMD);
            cmd_byte_q <= cmd_data;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written here receives a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d                 = state_q;
        index_d                 = index_q;
        byte_cnt_d              = byte_cnt_q;
        word_d                  = word_q;
        tx_valid                = 1'b0;
        tx_data                 = '0;
        debug_get_param         = 1'b0;
        debug_reg_addr          = '0;
        wait_continue_execution = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wait_for_continue) begin
                    state_d = S_HEADER;
                end
            end

            S_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_BYTE;
                if (tx_ready) begin
                    index_d = '0;
                    state_d = S_RD_ADDR;
                end
            end

            S_RD_ADDR: begin
                debug_get_param = 1'b1;
                debug_reg_addr  = index_q;
                state_d         = S_RD_CAP;
            end

            S_RD_CAP: begin
                // Address is held so the read stays stable while captured.
                debug_get_param = 1'b1;
                debug_reg_addr  = index_q;
                word_d          = 24'(debug_data_out);
                byte_cnt_d      = '0;
                state_d         = S_SEND;
            end

            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = word_q[7:0];
                if (tx_ready) begin
                    word_d     = {8'h00, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (index_q < LAST_INDEX) begin
                            index_d = index_q + 4'd1;
                            state_d = S_RD_ADDR;
                        end else begin
                            state_d = S_WAIT_CMD;
                        end
                    end
                end
            end

            S_WAIT_CMD: begin
                // Losing the halt flag wins over any pending command.
                if (!wait_for_continue) begin
                    state_d = S_IDLE;
                end else if (cmd_vld_q) begin
                    if (cmd_byte_q == CMD_RESUME) begin
                        state_d = S_RESUME;
                    end else if (cmd_byte_q == CMD_REDUMP) begin
                        state_d = S_HEADER;
                    end
                end
            end

            S_RESUME: begin
                wait_continue_execution = 1'b1;
                state_d                 = S_WAIT_CLEAR;
            end

            S_WAIT_CLEAR: begin
                // A halt flag still high from before the resume must not
                // start a new dump.
                if (!wait_for_continue) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_dump_controller.sv
// -----------------------------------------------------------------------------
// Directed bench for debug_dump_controller: reset state, a full dump under
// continuous ready, a dump under random back-pressure, command handling,
// re-dump, halt drop in WAIT_CMD and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_debug_dump_controller;

    localparam int WS        = 18;
    localparam int FRAME_LEN = 28;

    logic          clock = 1'b0;
    logic          reset;
    logic          wait_for_continue;
    logic          wait_continue_execution;
    logic          debug_get_param;
    logic [3:0]    debug_reg_addr;
    logic [WS-1:0] debug_data_out = '0;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          cmd_valid;
    logic [7:0]    cmd_data;
    logic          cmd_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    debug_dump_controller #(
        .WORD_SIZE  (WS),
        .REG_COUNT  (8),
        .HEADER_BYTE(8'hA5)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .wait_for_continue      (wait_for_continue),
        .wait_continue_execution(wait_continue_execution),
        .debug_get_param        (debug_get_param),
        .debug_reg_addr         (debug_reg_addr),
        .debug_data_out         (debug_data_out),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .tx_data                (tx_data),
        .cmd_valid              (cmd_valid),
        .cmd_data               (cmd_data),
        .cmd_ready              (cmd_ready),
        .busy                   (busy)
    );

    always #5 clock = ~clock;

    // Processor register file model: read data appears one cycle after the
    // address is presented with debug_get_param.
    logic [WS-1:0] regs [0:8];
    always @(posedge clock) begin
        if (debug_get_param && debug_reg_addr <= 4'd8)
            debug_data_out <= regs[debug_reg_addr];
    end

    // Link monitor, sampled on the falling edge: records every byte that will
    // be accepted at the next rising edge, counts resume-pulse cycles and
    // counts violations of the valid/data hold rule.
    logic [7:0] rx_mem [0:511];
    int         rx_cnt    = 0;
    int         pulses    = 0;
    int         hold_viol = 0;
    logic       pend_q    = 1'b0;
    logic [7:0] pend_data = '0;
    always @(negedge clock) begin
        if (tx_valid && tx_ready) begin
            rx_mem[rx_cnt] <= tx_data;
            rx_cnt         <= rx_cnt + 1;
        end
        if (pend_q && (!tx_valid || tx_data !== pend_data))
            hold_viol <= hold_viol + 1;
        pend_q    <= tx_valid && !tx_ready;
        pend_data <= tx_data;
        if (wait_continue_execution)
            pulses <= pulses + 1;
    end

    logic [7:0] exp_frame [0:FRAME_LEN-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_bytes(input int target, input int budget, input bit rand_ready,
                              input string tag);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tx_ready = 1'b1;
        check({tag, "_complete"}, 32'(rx_cnt >= target), 1);
    endtask

    task automatic compare_frame(input int base, input string tag);
        for (int i = 0; i < FRAME_LEN; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_mem[base + i]), 32'(exp_frame[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         busy_low;
        int         n;
        logic [23:0] w;

        regs[0] = 18'h2ABCD;
        for (int i = 1; i < 8; i++) regs[i] = 18'(i);
        regs[8] = 18'h00005;

        // Expected frame: header then each word, LSB first, zero-extended.
        exp_frame[0] = 8'hA5;
        for (int i = 0; i < 9; i++) begin
            w = 24'(regs[i]);
            exp_frame[1 + 3*i] = w[7:0];
            exp_frame[2 + 3*i] = w[15:8];
            exp_frame[3 + 3*i] = w[23:16];
        end

        reset             = 1'b1;
        wait_for_continue = 1'b0;
        tx_ready          = 1'b0;
        cmd_valid         = 1'b0;
        cmd_data          = '0;

        // ---- reset state ----------------------------------------------------
        tick();
        tick();
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_get_param", 32'(debug_get_param), 0);
        check("rst_resume", 32'(wait_continue_execution), 0);
        check("rst_reg_addr", 32'(debug_reg_addr), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // ---- basic dump, tx_ready held high ---------------------------------
        wait_for_continue = 1'b1;
        tx_ready          = 1'b1;
        base              = rx_cnt;
        tick();                                   // cycle 0: HEADER
        check("hdr_valid", 32'(tx_valid), 1);
        check("hdr_data", 32'(tx_data), 32'hA5);
        check("hdr_busy", 32'(busy), 1);
        check("hdr_get_param", 32'(debug_get_param), 0);
        tick();                                   // cycle 1: RD_ADDR r0
        check("rd_addr_get_param", 32'(debug_get_param), 1);
        check("rd_addr_addr", 32'(debug_reg_addr), 0);
        check("rd_addr_no_valid", 32'(tx_valid), 0);
        tick();                                   // cycle 2: RD_CAP r0
        check("rd_cap_get_param", 32'(debug_get_param), 1);
        check("rd_cap_addr", 32'(debug_reg_addr), 0);
        tick();                                   // cycle 3: first data byte
        check("send_valid", 32'(tx_valid), 1);
        check("send_first_byte", 32'(tx_data), 32'hCD);
        busy_low = 0;
        for (int k = 4; k <= 45; k++) begin
            tick();
            if (!busy) busy_low++;
            if (k == 41) begin                    // RD_ADDR of ip
                check("ip_addr", 32'(debug_reg_addr), 8);
                check("ip_get_param", 32'(debug_get_param), 1);
            end
        end
        check("last_byte_valid", 32'(tx_valid), 1);
        check("last_byte_data", 32'(tx_data), 0);
        tick();                                   // cycle 46: WAIT_CMD
        check("frame_done_valid", 32'(tx_valid), 0);
        check("frame_done_busy", 32'(busy), 1);
        check("frame_busy_gaps", 32'(busy_low), 0);
        check("frame_len", 32'(rx_cnt - base), FRAME_LEN);
        compare_frame(base, "basic");

        // ---- commands: junk ignored, then 'C' -------------------------------
        cmd_valid = 1'b1;
        cmd_data  = 8'h78;                        // 'x'
        tick();
        cmd_data  = 8'h00;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("junk_no_pulse", 32'(pulses), 0);
        check("junk_busy", 32'(busy), 1);
        check("junk_no_frame", 32'(tx_valid), 0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h43;                        // 'C'
        tick();                                   // handshake edge H
        cmd_valid = 1'b0;
        check("resume_not_yet", 32'(wait_continue_execution), 0);
        tick();                                   // high across edge H+2
        check("resume_pulse", 32'(wait_continue_execution), 1);
        tick();
        check("resume_one_cycle", 32'(wait_continue_execution), 0);
        base = rx_cnt;
        repeat (10) tick();
        check("wait_clear_pulses", 32'(pulses), 1);
        check("wait_clear_busy", 32'(busy), 1);
        check("wait_clear_no_frame", 32'(rx_cnt - base), 0);
        wait_for_continue = 1'b0;
        tick();
        check("clear_to_idle", 32'(busy), 0);
        tick();

        // ---- back-pressured dump --------------------------------------------
        wait_for_continue = 1'b1;
        base              = rx_cnt;
        wait_bytes(base + FRAME_LEN, 800, 1'b1, "bp");
        compare_frame(base, "bp");
        check("bp_hold_rule", 32'(hold_viol), 0);
        tick();
        check("bp_wait_cmd_valid", 32'(tx_valid), 0);
        check("bp_wait_cmd_busy", 32'(busy), 1);

        // ---- re-dump with 'D' -----------------------------------------------
        cmd_valid = 1'b1;
        cmd_data  = 8'h44;
        tick();
        cmd_valid = 1'b0;
        base      = rx_cnt;
        wait_bytes(base + FRAME_LEN, 200, 1'b0, "redump");
        compare_frame(base, "redump");
        repeat (3) tick();
        check("redump_len", 32'(rx_cnt - base), FRAME_LEN);
        check("redump_wait_valid", 32'(tx_valid), 0);
        check("redump_wait_busy", 32'(busy), 1);
        check("redump_no_pulse", 32'(pulses), 1);

        // ---- halt dropped in WAIT_CMD, later 'C' ignored ---------------------
        wait_for_continue = 1'b0;
        tick();
        check("halt_drop_busy", 32'(busy), 0);
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 8'h43;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("idle_c_no_pulse", 32'(pulses), 1);
        check("idle_c_busy", 32'(busy), 0);

        // ---- reset during the tenth byte ------------------------------------
        wait_for_continue = 1'b1;
        tx_ready          = 1'b1;
        base              = rx_cnt;
        n                 = 0;
        while (rx_cnt < base + 9 && n < 100) begin
            tick();
            n++;
        end
        check("pre_reset_reached", 32'(rx_cnt - base), 9);
        check("pre_reset_valid", 32'(tx_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 32'(tx_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_get_param", 32'(debug_get_param), 0);
        base = rx_cnt;
        tick();
        check("restart_valid", 32'(tx_valid), 1);
        check("restart_header", 32'(tx_data), 32'hA5);
        wait_bytes(base + FRAME_LEN, 200, 1'b0, "restart");
        compare_frame(base, "restart");
        tick();
        check("restart_done_busy", 32'(busy), 1);
        check("final_hold_rule", 32'(hold_viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_dump_controller.md
Name: debug_dump_controller

Overview:
- Sits directly downstream of the 18-bit processor's halt/debug interface.
- When the processor halts (wait_for_continue=1), the block reads r0..r7 and ip through the debug port and streams them as a byte frame over a ready/valid byte interface to the UART transmitter.
- It then waits for a host command byte and either pulses wait_continue_execution to resume the processor, or re-sends the frame.
- It replaces the bench-side print/check tasks in hardware builds.

Parameters:
- WORD_SIZE, 18, register/ip width; must be 17..24 so that each word packs into 3 bytes.
- REG_COUNT, 8, number of general registers dumped; ip is read at debug address REG_COUNT.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wait_for_continue  in  1  processor halted flag.
- wait_continue_execution  out  1  one-cycle resume pulse to processor.
- debug_get_param  out  1  debug read enable.
- debug_reg_addr  out  4  debug address: 0..7 = r0..r7, 8 = ip.
- debug_data_out  in  WORD_SIZE  debug read data, valid 1 cycle after address is driven.
- tx_valid  out  1  byte available.
- tx_ready  in  1  sink accepts byte when tx_valid&&tx_ready.
- tx_data  out  8  byte to send.
- cmd_valid  in  1  host command byte present.
- cmd_data  in  8  host command byte.
- cmd_ready  out  1  always 1; a byte is consumed whenever cmd_valid=1.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; wait_continue_execution, debug_get_param, tx_valid, busy = 0; debug_reg_addr=0; tx_data=0; index=0. Reset asserted mid-frame abandons the frame immediately; no further bytes are sent. cmd_ready stays 1.
- IDLE -> HEADER when wait_for_continue=1.
- HEADER: tx_valid=1, tx_data=HEADER_BYTE. On handshake -> RD_ADDR with index=0.
- RD_ADDR (1 cycle): debug_get_param=1, debug_reg_addr=index -> RD_CAP.
- RD_CAP (1 cycle): debug_get_param=1, address held; capture debug_data_out into a 24-bit zero-extended shift word -> SEND, byte counter=0.
- SEND: tx_valid=1, tx_data = word[7:0], then [15:8], then [23:16] (LSB first). Advance a byte only on handshake.
  - After the 3rd byte: if index<REG_COUNT, index+1 -> RD_ADDR; else -> WAIT_CMD.
  - Frame length = 1 + 3*(REG_COUNT+1) = 28 bytes.
- Handshake rule: once tx_valid is raised, it stays high and tx_data stays stable until tx_ready=1 at a rising edge. tx_ready while tx_valid=0 has no effect. Back-to-back bytes are allowed (1 byte/cycle under continuous ready).
- Minimum frame time with tx_ready tied high: 1 + 9*(2+3) = 46 cycles from the HEADER entry.
- WAIT_CMD:
  - cmd 8'h43 ('C') -> RESUME.
  - cmd 8'h44 ('D') -> HEADER (full re-dump).
  - Any other byte is dropped.
  - If wait_for_continue drops here -> IDLE with no pulse.
  - cmd bytes received in any other state are dropped.
- RESUME (1 cycle): wait_continue_execution=1 -> WAIT_CLEAR.
- WAIT_CLEAR: wait for wait_for_continue=0, then -> IDLE. This prevents a stale halt flag from retriggering a dump.
- wait_for_continue dropping during HEADER/RD/SEND does not abort; the frame completes and the next state is WAIT_CMD (which then exits to IDLE per the rule above).
- Upper byte of each word: bits [23:WORD_SIZE] are zero (for WORD_SIZE=18, byte 3 is at most 8'h03).

Test Plan:
- Basic dump: r0=18'h2ABCD, r1..r7=n, ip=18'h00005, tx_ready=1, assert wait_for_continue. Required: 28 bytes A5, CD, AB, 02, 01, 00, 00, ..., 05, 00, 00 on consecutive handshakes; the header is followed by 2 idle cycles per word; busy=1 throughout.
- Backpressure: random tx_ready with 50% duty. Required: identical byte sequence; tx_data never changes while tx_valid&&!tx_ready; tx_valid never drops before a handshake.
- Commands: after the frame, send 'x', 8'h00, then 'C'. Required: first two ignored; wait_continue_execution high exactly 1 cycle, 2 cycles after the 'C' handshake edge; no pulse if wait_for_continue stays high after that (WAIT_CLEAR holds, no new frame until it falls and rises again).
- Re-dump: send 'D' in WAIT_CMD. Required: a second identical 28-byte frame, then WAIT_CMD again with no resume pulse.
- Reset mid-frame: assert reset during byte 10 for 1 cycle. Required: next edge tx_valid=0, busy=0, debug_get_param=0; a fresh frame starting with A5 follows if wait_for_continue is still high.
- Halt dropped in WAIT_CMD: deassert wait_for_continue. Required: return to IDLE, busy=0, no wait_continue_execution pulse; a later 'C' is ignored.
